// File: rtl/fifo2uart.sv
// FIFO-to-UART return path: pops words from a FIFO read port and sends each one
// as 8N1 bytes, most-significant byte first.
module fifo2uart #(
    parameter int DATA_WIDTH   = 16,
    parameter int CLKS_PER_BIT = 87
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_empty,
    output logic                  o_rd_en,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_byte_done,
    output logic                  o_word_done
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int CW     = $clog2(CLKS_PER_BIT);
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [BW-1:0]         byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [7:0]            cur_byte;
    logic                  last_clk;
    logic                  last_byte;

    assign last_clk  = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
    assign last_byte = (byte_idx_q == BW'(NBYTES - 1));

    // Byte 0 is the top byte of the word.
    always_comb begin
        cur_byte = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            if (byte_idx_q == BW'(b)) cur_byte = word_q[DATA_WIDTH-1-8*b -: 8];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = '0;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        o_rd_en     = 1'b0;
        o_tx        = 1'b1;
        o_busy      = 1'b1;
        o_byte_done = 1'b0;
        o_word_done = 1'b0;

        // Bit-period counter runs only while a frame is on the line.
        if (state_q == START || state_q == DATA || state_q == STOP)
            clk_cnt_d = last_clk ? '0 : clk_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                o_busy = 1'b0;
                if (i_en && !i_empty) state_d = FETCH;
            end
            FETCH: begin
                o_rd_en = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                word_d     = i_rd_data;
                byte_idx_d = '0;
                state_d    = START;
            end
            START: begin
                o_tx = 1'b0;
                if (last_clk) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                o_tx = cur_byte[bit_idx_q];
                if (last_clk) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (last_clk) begin
                    o_byte_done = 1'b1;
                    if (last_byte) begin
                        o_word_done = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo2uart.sv
// Directed bench for fifo2uart: FIFO model on the read port, cycle-exact line
// checks against hand-written byte tables, and a behavioural UART receiver.
module tb_fifo2uart;

    localparam int DW  = 16;
    localparam int CPB = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_en  = 1'b1;
    logic          i_empty = 1'b1;
    logic          o_rd_en;
    logic [DW-1:0] i_rd_data = '0;
    logic          o_tx, o_busy, o_byte_done, o_word_done;

    fifo2uart #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_empty(i_empty),
        .o_rd_en(o_rd_en), .i_rd_data(i_rd_data), .o_tx(o_tx), .o_busy(o_busy),
        .o_byte_done(o_byte_done), .o_word_done(o_word_done)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    logic [DW-1:0] fifo[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    // FIFO model: data valid the cycle after the read strobe.
    always @(posedge i_clk) begin
        if (o_rd_en) begin
            if (fifo.size() > 0) i_rd_data <= fifo.pop_front();
            i_empty <= (fifo.size() == 0);
        end
    end

    task automatic push(input logic [DW-1:0] w);
        fifo.push_back(w);
        i_empty = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural 8N1 receiver sampling mid-bit on the falling edge.
    logic       rx_en = 1'b0, rx_busy = 1'b0;
    int         rx_cnt = 0, rx_ferr = 0;
    logic [7:0] rx_sh = '0;
    logic [7:0] rx_q[$];

    always @(negedge i_clk) begin
        if (!rx_en) begin
            rx_busy <= 1'b0;
        end else if (!rx_busy) begin
            if (!o_tx) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt - 6) % 4 == 0)
                rx_sh <= {o_tx, rx_sh[7:1]};
            if (rx_cnt == 38) begin
                rx_busy <= 1'b0;
                rx_q.push_back(rx_sh);
                if (!o_tx) rx_ferr <= rx_ferr + 1;
            end
        end
    end

    // Waits for a read strobe, then checks the 82 following cycles against the
    // expected frame for bytes b0,b1. drop_at>0 lowers i_en at that cycle.
    task automatic run_word(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input int drop_at, output int t_rd);
        int n = 0;
        int e_tx = 0, e_bd = 0, e_wd = 0, e_busy = 0, e_rd = 0;
        logic [7:0] bt;
        logic ex_tx, ex_bd, ex_wd, ex_busy;
        t_rd = -1;
        @(negedge i_clk);
        while (!o_rd_en && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        chk({tag, " rd_en seen"}, {31'd0, o_rd_en}, 32'd1);
        if (!o_rd_en) return;
        t_rd = cyc;
        if (!o_busy) e_busy++;
        for (int k = 1; k <= 82; k++) begin
            @(negedge i_clk);
            if (k == drop_at) i_en = 1'b0;
            ex_tx = 1'b1; ex_bd = 1'b0; ex_wd = 1'b0; ex_busy = (k <= 81);
            if (k >= 2 && k <= 81) begin
                int idx, slot;
                idx  = k - 2;
                bt   = (idx < 40) ? b0 : b1;
                slot = (idx % 40) / 4;
                if (slot == 0) ex_tx = 1'b0;
                else if (slot <= 8) ex_tx = bt[slot-1];
            end
            if (k == 41 || k == 81) ex_bd = 1'b1;
            if (k == 81) ex_wd = 1'b1;
            if (o_tx !== ex_tx) e_tx++;
            if (o_byte_done !== ex_bd) e_bd++;
            if (o_word_done !== ex_wd) e_wd++;
            if (o_busy !== ex_busy) e_busy++;
            if (o_rd_en !== 1'b0) e_rd++;
        end
        chk({tag, " line errors"}, e_tx, 0);
        chk({tag, " byte_done errors"}, e_bd, 0);
        chk({tag, " word_done errors"}, e_wd, 0);
        chk({tag, " busy errors"}, e_busy, 0);
        chk({tag, " stray rd_en"}, e_rd, 0);
    endtask

    typedef struct {
        logic [15:0] w;
        logic [7:0]  b0, b1;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int t1, t2, errs;
        logic [7:0] exp_q[$];

        vecs[0] = '{16'hA55A, 8'hA5, 8'h5A};
        vecs[1] = '{16'h00FF, 8'h00, 8'hFF};
        vecs[2] = '{16'hFF00, 8'hFF, 8'h00};
        vecs[3] = '{16'h8001, 8'h80, 8'h01};
        vecs[4] = '{16'h7E3C, 8'h7E, 8'h3C};

        // Reset state
        repeat (2) @(negedge i_clk);
        chk("reset outputs", {27'd0, o_tx, o_busy, o_rd_en, o_byte_done, o_word_done}, 32'h10);
        i_rst = 1'b0;

        // Empty FIFO: nothing happens
        errs = 0;
        repeat (200) begin
            @(negedge i_clk);
            if (o_rd_en || !o_tx || o_busy) errs++;
        end
        chk("empty idle errors", errs, 0);

        // Table of single words
        foreach (vecs[i]) begin
            push(vecs[i].w);
            run_word($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, 0, t1);
        end

        // Back-to-back words: strobes 83 cycles apart
        push(16'h1234);
        push(16'hABCD);
        run_word("b2b first", 8'h12, 8'h34, 0, t1);
        run_word("b2b second", 8'hAB, 8'hCD, 0, t2);
        chk("b2b rd_en spacing", t2 - t1, 83);

        // Reset in the middle of byte 0's data bits
        push(16'h5AA5);
        errs = 0;
        @(negedge i_clk);
        while (!o_rd_en && errs < 300) begin
            @(negedge i_clk);
            errs++;
        end
        chk("rst test rd_en seen", {31'd0, o_rd_en}, 32'd1);
        repeat (15) @(negedge i_clk);
        chk("pre-reset busy", {31'd0, o_busy}, 32'd1);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("post-reset tx/busy", {30'd0, o_tx, o_busy}, 32'h2);
        i_rst = 1'b0;
        push(16'hC33C);
        run_word("after reset", 8'hC3, 8'h3C, 0, t1);

        // i_en dropped during byte 0: word completes, no further fetch
        push(16'h0F0F);
        push(16'hF00F);
        run_word("en drop", 8'h0F, 8'h0F, 10, t1);
        errs = 0;
        repeat (120) begin
            @(negedge i_clk);
            if (o_rd_en || o_busy) errs++;
        end
        chk("no fetch while disabled", errs, 0);
        i_en = 1'b1;
        run_word("re-enabled", 8'hF0, 8'h0F, 0, t1);

        // Loopback into a receiver with random words
        rx_q.delete();
        rx_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            push(w);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
        errs = 0;
        while (rx_q.size() < 16 && errs < 8 * 83 + 200) begin
            @(negedge i_clk);
            errs++;
        end
        chk("loopback byte count", rx_q.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < rx_q.size()) chk($sformatf("loopback byte %0d", i), rx_q[i], exp_q[i]);
        chk("loopback framing errors", rx_ferr, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
